// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared fetch-stage types: FSM state encoding and instruction width.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int c_inst_width = 32;
  localparam int c_byte_width = 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dbg_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : dbg_word_assembler
// Purpose  : Packs debug bytes (first byte most significant) into instruction
//            words and pulses o_word_valid on the byte that completes a word.
// Revision : 1.0 - initial release
// ============================================================================
module dbg_word_assembler
  import mips_pkg::*;
#(
  parameter int SIZE_INST = c_inst_width
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_byte_valid,
  input  logic [7:0]           i_byte,
  output logic [SIZE_INST-1:0] o_word,
  output logic                 o_word_valid
);

  localparam int c_num_bytes = SIZE_INST / c_byte_width;
  localparam int c_cnt_w     = (c_num_bytes > 1) ? $clog2(c_num_bytes) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_num_bytes - 1);

  logic [c_cnt_w-1:0] r_count;

  assign o_word_valid = i_byte_valid && (r_count == c_last);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_byte_valid) begin
      r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
    end
  end

  generate
    if (c_num_bytes > 1) begin : g_multi
      // Holds the older bytes; the completing byte is appended combinationally.
      logic [SIZE_INST-9:0] r_shift;
      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          r_shift <= '0;
        end else if (i_byte_valid) begin
          r_shift <= o_word[SIZE_INST-9:0];
        end
      end
      assign o_word = {r_shift, i_byte};
    end else begin : g_single
      assign o_word = i_byte;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage with debug program loader and LOAD/RUN/
//            STALL/HALT control. FETCH_UNIT_PERF_CNT_EN enables o_fetch_count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import mips_pkg::*;
#(
  parameter int SIZE_PC   = 32,
  parameter int SIZE_INST = c_inst_width,
  parameter int MEM_DEPTH = 256
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_run,
  input  logic                       i_stall,
  input  logic                       i_halt,
  input  logic                       i_branch_taken,
  input  logic [SIZE_PC-1:0]         i_branch_target,
  input  logic                       i_dbg_byte_valid,
  input  logic [7:0]                 i_dbg_byte,
  input  logic                       i_dbg_clear,
  output logic [SIZE_PC-1:0]         o_pc,
  output logic [SIZE_PC-1:0]         o_pc_plus4,
  output logic [SIZE_INST-1:0]       o_instruction,
  output logic                       o_inst_valid,
  output logic [1:0]                 o_state,
  output logic [$clog2(MEM_DEPTH):0] o_word_count,
  output logic                       o_load_overflow,
  output logic                       o_addr_error,
  output logic [31:0]                o_fetch_count
);

  localparam int c_idx_w = $clog2(MEM_DEPTH);
  localparam int c_cnt_w = c_idx_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(MEM_DEPTH);
  localparam logic [SIZE_PC-1:0] c_four = SIZE_PC'(4);

  state_t               r_state;
  logic [SIZE_PC-1:0]   r_pc;
  logic [SIZE_INST-1:0] r_instruction;
  logic                 r_inst_valid;
  logic                 r_load_overflow;
  logic                 r_addr_error;
  logic [c_cnt_w-1:0]   r_word_count;
  logic [SIZE_INST-1:0] r_mem [MEM_DEPTH];

  logic                 w_mem_full;
  logic                 w_byte_accept;
  logic                 w_asm_clear;
  logic [SIZE_INST-1:0] w_word;
  logic                 w_word_valid;
  logic [SIZE_PC-1:0]   w_next_pc;
  logic [c_idx_w-1:0]   w_next_idx;
  logic                 w_next_bad;

  assign w_mem_full    = (r_word_count == c_full);
  assign w_byte_accept = i_enable && !i_dbg_clear && (r_state == ST_LOAD) && !i_run
                         && i_dbg_byte_valid && !w_mem_full;
  // Entering RUN drops any partially assembled word, as does a debug clear.
  assign w_asm_clear   = i_enable && (i_dbg_clear || ((r_state == ST_LOAD) && i_run));

  assign w_next_pc  = i_branch_taken ? i_branch_target : r_pc + c_four;
  assign w_next_idx = w_next_pc[c_idx_w+1:2];
  assign w_next_bad = (w_next_pc[1:0] != 2'b00) || ({1'b0, w_next_idx} >= r_word_count);

  dbg_word_assembler #(
    .SIZE_INST (SIZE_INST)
  ) u_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_asm_clear),
    .i_byte_valid (w_byte_accept),
    .i_byte       (i_dbg_byte),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clk) begin
    if (w_word_valid) begin
      r_mem[r_word_count[c_idx_w-1:0]] <= w_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state         <= ST_LOAD;
      r_pc            <= '0;
      r_instruction   <= '0;
      r_inst_valid    <= 1'b0;
      r_word_count    <= '0;
      r_load_overflow <= 1'b0;
      r_addr_error    <= 1'b0;
    end else if (i_enable) begin
      if (i_dbg_clear) begin
        r_state         <= ST_LOAD;
        r_pc            <= '0;
        r_inst_valid    <= 1'b0;
        r_word_count    <= '0;
        r_load_overflow <= 1'b0;
        r_addr_error    <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (i_run) begin
              r_state       <= ST_RUN;
              r_pc          <= '0;
              r_instruction <= r_mem[0];
              r_inst_valid  <= 1'b1;
            end else if (i_dbg_byte_valid) begin
              if (w_mem_full) begin
                r_load_overflow <= 1'b1;
              end else if (w_word_valid) begin
                r_word_count <= r_word_count + 1'b1;
              end
            end
          end
          // Releasing a stall fetches on the same edge, so no slot is lost.
          ST_RUN, ST_STALL: begin
            if (i_halt) begin
              r_state      <= ST_HALT;
              r_inst_valid <= 1'b0;
            end else if (i_stall) begin
              r_state <= ST_STALL;
            end else if (w_next_bad) begin
              r_state      <= ST_HALT;
              r_inst_valid <= 1'b0;
              r_addr_error <= 1'b1;
            end else begin
              r_state       <= ST_RUN;
              r_pc          <= w_next_pc;
              r_instruction <= r_mem[w_next_idx];
              r_inst_valid  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef FETCH_UNIT_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic        w_count_event;

  assign w_count_event = i_enable && !i_dbg_clear &&
                         (((r_state == ST_LOAD) && i_run) ||
                          (((r_state == ST_RUN) || (r_state == ST_STALL)) &&
                           !i_halt && !i_stall && !w_next_bad));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fetch_count <= '0;
    end else if (i_enable && i_dbg_clear) begin
      r_fetch_count <= '0;
    end else if (w_count_event && (r_fetch_count != 32'hFFFF_FFFF)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`else
  assign o_fetch_count = '0;
`endif

  assign o_pc            = r_pc;
  assign o_pc_plus4      = r_pc + c_four;
  assign o_instruction   = r_instruction;
  assign o_inst_valid    = r_inst_valid;
  assign o_state         = r_state;
  assign o_word_count    = r_word_count;
  assign o_load_overflow = r_load_overflow;
  assign o_addr_error    = r_addr_error;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed and randomized checks of fetch_unit against a
//            transaction-level model of the loader and fetch rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_run = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_halt = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_target = '0;
  logic        i_dbg_byte_valid = 1'b0;
  logic [7:0]  i_dbg_byte = '0;
  logic        i_dbg_clear = 1'b0;
  logic [31:0] o_pc, o_pc_plus4, o_instruction, o_fetch_count;
  logic        o_inst_valid, o_load_overflow, o_addr_error;
  logic [1:0]  o_state;
  logic [2:0]  o_word_count;

  fetch_unit #(.SIZE_PC(32), .SIZE_INST(32), .MEM_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_run(i_run),
    .i_stall(i_stall), .i_halt(i_halt), .i_branch_taken(i_branch_taken),
    .i_branch_target(i_branch_target), .i_dbg_byte_valid(i_dbg_byte_valid),
    .i_dbg_byte(i_dbg_byte), .i_dbg_clear(i_dbg_clear), .o_pc(o_pc),
    .o_pc_plus4(o_pc_plus4), .o_instruction(o_instruction), .o_inst_valid(o_inst_valid),
    .o_state(o_state), .o_word_count(o_word_count), .o_load_overflow(o_load_overflow),
    .o_addr_error(o_addr_error), .o_fetch_count(o_fetch_count)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: program words, pending bytes, architectural state.
  logic [31:0] m_mem [DEPTH];
  logic [7:0]  m_bytes [$];
  logic [1:0]  m_state;
  logic [31:0] m_pc, m_inst;
  logic        m_valid, m_ovf, m_err;
  int          m_wc;
  longint      m_fc;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_pc = 0; m_inst = 0; m_valid = 0;
    m_wc = 0; m_ovf = 0; m_err = 0; m_fc = 0;
    m_bytes.delete();
  endtask

  task automatic count_fetch();
    if (m_fc < 64'hFFFF_FFFF) m_fc++;
  endtask

  task automatic model_step();
    logic [31:0] np;
    int idx;
    if (!i_enable) return;
    if (i_dbg_clear) begin
      m_state = 2'd0; m_pc = 0; m_valid = 0; m_wc = 0;
      m_ovf = 0; m_err = 0; m_fc = 0; m_bytes.delete();
      return;
    end
    case (m_state)
      2'd0: begin
        if (i_run) begin
          m_bytes.delete();
          m_state = 2'd1; m_pc = 0; m_inst = m_mem[0]; m_valid = 1;
          count_fetch();
        end else if (i_dbg_byte_valid) begin
          if (m_wc == DEPTH) m_ovf = 1;
          else begin
            m_bytes.push_back(i_dbg_byte);
            if (m_bytes.size() == 4) begin
              m_mem[m_wc] = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
              m_wc++;
              m_bytes.delete();
            end
          end
        end
      end
      2'd1, 2'd2: begin
        if (i_halt) begin
          m_state = 2'd3; m_valid = 0;
        end else if (i_stall) begin
          m_state = 2'd2;
        end else begin
          np  = i_branch_taken ? i_branch_target : m_pc + 32'd4;
          idx = int'((np >> 2) % DEPTH);
          if (np[1:0] != 2'b00 || idx >= m_wc) begin
            m_err = 1; m_state = 2'd3; m_valid = 0;
          end else begin
            m_pc = np; m_inst = m_mem[idx]; m_state = 2'd1; m_valid = 1;
            count_fetch();
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    logic [31:0] e_pc4;
    logic [31:0] e_fc;
    e_pc4 = m_pc + 32'd4;
`ifdef FETCH_UNIT_PERF_CNT_EN
    e_fc = m_fc[31:0];
`else
    e_fc = '0;
`endif
    check("state", o_state, m_state);
    check("pc", o_pc, m_pc);
    check("pc_plus4", o_pc_plus4, e_pc4);
    check("inst_valid", o_inst_valid, m_valid);
    if (m_valid) check("instruction", o_instruction, m_inst);
    check("word_count", o_word_count, m_wc);
    check("load_overflow", o_load_overflow, m_ovf);
    check("addr_error", o_addr_error, m_err);
    check("fetch_count", o_fetch_count, e_fc);
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    i_enable = 1; i_run = 0; i_stall = 0; i_halt = 0; i_branch_taken = 0;
    i_dbg_byte_valid = 0; i_dbg_clear = 0;
  endtask

  task automatic load_word(logic [31:0] w, bit gaps);
    for (int k = 0; k < 4; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        // Byte strobes while disabled must be ignored.
        i_enable = 0; i_dbg_byte_valid = 1; i_dbg_byte = 8'($urandom);
        tick();
        i_enable = 1; i_dbg_byte_valid = 0;
      end
      i_dbg_byte_valid = 1; i_dbg_byte = w[31-8*k -: 8];
      tick();
      i_dbg_byte_valid = 0;
    end
  endtask

  task automatic pulse_run();   i_run = 1;       tick(); i_run = 0;       endtask
  task automatic pulse_clear(); i_dbg_clear = 1; tick(); i_dbg_clear = 0; endtask

  task automatic async_reset();
    i_reset = 0;
    model_reset();
    #1;
    check_all();
    check("reset_instruction", o_instruction, 32'h0);
    i_reset = 1;
  endtask

  initial begin
    #1_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    #2;
    async_reset();
    idle_inputs();

    // Two-word program, runs off its end into an address error.
    load_word(32'h20010005, 0);
    load_word(32'h20020007, 0);
    check("r21_word_count", o_word_count, 3'd2);
    pulse_run();
    check("r21_inst0", o_instruction, 32'h20010005);
    tick();
    check("r21_pc1", o_pc, 32'h4);
    check("r21_inst1", o_instruction, 32'h20020007);
    tick();
    check("r21_error", o_addr_error, 1'b1);
    check("r21_halt", o_state, 2'd3);

    // Stall hold and resume.
    pulse_clear();
    for (int k = 0; k < 4; k++) load_word(32'hA0000000 + 32'(k), 0);
    pulse_run();
    tick();
    i_stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("r22_hold_pc", o_pc, 32'h4);
      check("r22_hold_valid", o_inst_valid, 1'b1);
    end
    i_stall = 0;
    tick();
    check("r22_resume_pc", o_pc, 32'h8);

    // Branches: aligned in range, then misaligned.
    pulse_clear();
    for (int k = 0; k < 4; k++) load_word(32'hB0000000 + 32'(k), 1);
    pulse_run();
    i_branch_taken = 1; i_branch_target = 32'hC;
    tick();
    check("r23_branch_pc", o_pc, 32'hC);
    i_branch_target = 32'h6;
    tick();
    check("r23_misaligned", o_addr_error, 1'b1);
    i_branch_taken = 0;

    // Halt beats stall beats branch.
    pulse_clear();
    load_word(32'h11111111, 0);
    load_word(32'h22222222, 0);
    pulse_run();
    i_halt = 1; i_stall = 1; i_branch_taken = 1; i_branch_target = 32'h4;
    tick();
    check("r24_state", o_state, 2'd3);
    check("r24_valid", o_inst_valid, 1'b0);
    idle_inputs();
    pulse_clear();
    check("r24_clear_state", o_state, 2'd0);
    check("r24_clear_wc", o_word_count, 3'd0);

    // Overflow and asynchronous reset mid-run.
    for (int k = 0; k < 5; k++) load_word(32'hC0DE0000 + 32'(k), 0);
    check("r25_wc", o_word_count, 3'd4);
    check("r25_ovf", o_load_overflow, 1'b1);
    pulse_run();
    tick();
    #3;
    async_reset();

    // Fetch counter: 10 fetches around 3 stall cycles.
    pulse_clear();
    for (int k = 0; k < 4; k++) load_word(32'hD0000000 + 32'(k), 0);
    pulse_run();
    repeat (3) tick();
    i_stall = 1; repeat (3) tick(); i_stall = 0;
    i_branch_taken = 1; i_branch_target = 32'h0; tick(); i_branch_taken = 0;
    repeat (3) tick();
    i_branch_taken = 1; tick(); i_branch_taken = 0;
    tick();
`ifdef FETCH_UNIT_PERF_CNT_EN
    check("r26_fetch_count", o_fetch_count, 32'd10);
`else
    check("r26_fetch_count", o_fetch_count, 32'd0);
`endif

    // Randomized sessions.
    for (int it = 0; it < 200; it++) begin
      idle_inputs();
      pulse_clear();
      for (int k = $urandom_range(0, 5); k > 0; k--) load_word($urandom, 1);
      pulse_run();
      for (int c = $urandom_range(1, 25); c > 0; c--) begin
        i_enable         = ($urandom_range(0, 9) != 0);
        i_stall          = ($urandom_range(0, 4) == 0);
        i_halt           = ($urandom_range(0, 29) == 0);
        i_branch_taken   = ($urandom_range(0, 4) == 0);
        i_run            = ($urandom_range(0, 9) == 0);
        i_dbg_byte_valid = $urandom_range(0, 1);
        i_dbg_byte       = 8'($urandom);
        i_dbg_clear      = ($urandom_range(0, 49) == 0);
        case ($urandom_range(0, 9))
          0:       i_branch_target = $urandom_range(0, 31);
          1:       i_branch_target = 32'hFFFF_FFFC;
          default: i_branch_target = 32'($urandom_range(0, 7)) * 32'd4;
        endcase
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
